// File: rtl/mc_control_fsm_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W   = 4;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned ALU_CTL_W = 3;
  localparam int unsigned SRCB_W    = 2;
  localparam int unsigned PCSRC_W   = 2;

  // Control states; the lw path occupies encodings 0..4 in execution order.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  // Opcodes (IR[31:26]).
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  // R-type function codes (IR[5:0]).
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  // ALU control codes; bit 2 selects carry-in/invert of operand B.
  localparam logic [ALU_CTL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_CTL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_CTL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_CTL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_CTL_W-1:0] ALU_SLT = 3'b111;

  // ALU operand B select.
  localparam logic [SRCB_W-1:0] SRCB_REGB    = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select.
  localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control payload driven each cycle.
  typedef struct packed {
    logic [ALU_CTL_W-1:0] alu_ctl;
    logic                 alu_src_a;
    logic [SRCB_W-1:0]    alu_src_b;
    logic                 iord;
    logic                 mem_read;
    logic                 mem_write;
    logic                 ir_write;
    logic                 reg_dst;
    logic                 mem_to_reg;
    logic                 reg_write;
    logic [PCSRC_W-1:0]   pc_src;
    logic                 pc_write;
    logic                 illegal;
  } ctrl_t;

  // Idle control word: everything low, ALU left on ADD.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c         = '0;
    c.alu_ctl = ALU_ADD;
    return c;
  endfunction

  // Kill every side-effecting strobe, leaving the mux selects alone.
  function automatic ctrl_t clear_strobes(input ctrl_t c_in);
    ctrl_t c;
    c           = c_in;
    c.mem_read  = 1'b0;
    c.mem_write = 1'b0;
    c.ir_write  = 1'b0;
    c.reg_write = 1'b0;
    c.pc_write  = 1'b0;
    c.illegal   = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control/datapath boundary: IR fields and zero flag in, control strobes out.
interface mc_control_fsm_if;

  logic [mc_ctrl_pkg::OP_W-1:0]      opcode;
  logic [mc_ctrl_pkg::FUNCT_W-1:0]   funct;
  logic                              zero;
  logic [mc_ctrl_pkg::ALU_CTL_W-1:0] aluCtl;
  logic                              aluSrcA;
  logic [mc_ctrl_pkg::SRCB_W-1:0]    aluSrcB;
  logic                              iorD;
  logic                              memRead;
  logic                              memWrite;
  logic                              irWrite;
  logic                              regDst;
  logic                              memToReg;
  logic                              regWrite;
  logic [mc_ctrl_pkg::PCSRC_W-1:0]   pcSrc;
  logic                              pcWrite;
  logic                              illegal;
  logic [mc_ctrl_pkg::STATE_W-1:0]   state;

  // Control FSM side.
  modport master (
    input  opcode, funct, zero,
    output aluCtl, aluSrcA, aluSrcB, iorD, memRead, memWrite, irWrite,
           regDst, memToReg, regWrite, pcSrc, pcWrite, illegal, state
  );

  // Datapath side.
  modport slave (
    output opcode, funct, zero,
    input  aluCtl, aluSrcA, aluSrcB, iorD, memRead, memWrite, irWrite,
           regDst, memToReg, regWrite, pcSrc, pcWrite, illegal, state
  );

endinterface

// File: rtl/mc_control_fsm_alu_ctl_decode.sv
// R-type funct field to ALU control code, with a flag for supported functs.
module alu_ctl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [FUNCT_W-1:0]   funct,
  output logic [ALU_CTL_W-1:0] alu_ctl_c,
  output logic                 funct_valid_c
);

  // Map funct onto ALU operation; unsupported codes fall back to ADD.
  always_comb begin
    alu_ctl_c     = ALU_ADD;
    funct_valid_c = 1'b1;
    case (funct)
      FN_ADD:  alu_ctl_c = ALU_ADD;
      FN_SUB:  alu_ctl_c = ALU_SUB;
      FN_AND:  alu_ctl_c = ALU_AND;
      FN_OR:   alu_ctl_c = ALU_OR;
      FN_SLT:  alu_ctl_c = ALU_SLT;
      default: funct_valid_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control: state register plus decoded datapath controls.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mc_control_fsm_if.master bus
);

  state_t                 state_q;
  state_t                 state_n;
  ctrl_t                  ctl_c;
  logic [ALU_CTL_W-1:0]   fn_alu_ctl_c;
  logic                   fn_valid_c;

  alu_ctl_decode u_alu_ctl_decode (
    .funct         (bus.funct),
    .alu_ctl_c     (fn_alu_ctl_c),
    .funct_valid_c (fn_valid_c)
  );

  // State register; reset restarts at instruction fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state and per-state controls; reset suppresses all strobes.
  always_comb begin
    state_n = S_FETCH;
    ctl_c   = ctrl_idle();
    case (state_q)
      S_FETCH: begin
        ctl_c.mem_read  = 1'b1;
        ctl_c.ir_write  = 1'b1;
        ctl_c.alu_src_b = SRCB_FOUR;
        ctl_c.pc_src    = PCSRC_ALU;
        ctl_c.pc_write  = 1'b1;
        state_n         = S_DECODE;
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut.
        ctl_c.alu_src_b = SRCB_IMM_SH2;
        case (bus.opcode)
          OP_RTYPE:     state_n = S_EXEC;
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_BEQ:       state_n = S_BRANCH;
          OP_J:         state_n = S_JUMP;
          OP_ADDI:      state_n = S_ADDIEX;
          default: begin
            ctl_c.illegal = 1'b1;
            state_n       = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_IMM;
        state_n         = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctl_c.mem_read = 1'b1;
        ctl_c.iord     = 1'b1;
        state_n        = S_MEMWB;
      end
      S_MEMWB: begin
        ctl_c.mem_to_reg = 1'b1;
        ctl_c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctl_c.mem_write = 1'b1;
        ctl_c.iord      = 1'b1;
      end
      S_EXEC: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_REGB;
        if (fn_valid_c) begin
          ctl_c.alu_ctl = fn_alu_ctl_c;
          state_n       = S_RWB;
        end else begin
          ctl_c.illegal = 1'b1;
        end
      end
      S_RWB: begin
        ctl_c.reg_dst   = 1'b1;
        ctl_c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_REGB;
        ctl_c.alu_ctl   = ALU_SUB;
        ctl_c.pc_src    = PCSRC_ALUOUT;
        ctl_c.pc_write  = bus.zero;
      end
      S_JUMP: begin
        ctl_c.pc_src   = PCSRC_JUMP;
        ctl_c.pc_write = 1'b1;
      end
      S_ADDIEX: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_IMM;
        state_n         = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctl_c.reg_write = 1'b1;
      end
      default: begin
        state_n = S_FETCH;
      end
    endcase
    if (rst) begin
      ctl_c = clear_strobes(ctl_c);
    end
  end

  // Drive the interface from the decoded control word.
  assign bus.aluCtl   = ctl_c.alu_ctl;
  assign bus.aluSrcA  = ctl_c.alu_src_a;
  assign bus.aluSrcB  = ctl_c.alu_src_b;
  assign bus.iorD     = ctl_c.iord;
  assign bus.memRead  = ctl_c.mem_read;
  assign bus.memWrite = ctl_c.mem_write;
  assign bus.irWrite  = ctl_c.ir_write;
  assign bus.regDst   = ctl_c.reg_dst;
  assign bus.memToReg = ctl_c.mem_to_reg;
  assign bus.regWrite = ctl_c.reg_write;
  assign bus.pcSrc    = ctl_c.pc_src;
  assign bus.pcWrite  = ctl_c.pc_write;
  assign bus.illegal  = ctl_c.illegal;
  assign bus.state    = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-instruction cycle schedules vs. DUT.
module tb_mc_control_fsm;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One cycle's worth of observable controls.
  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu;
    logic       a;
    logic [1:0] b;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       rd;
    logic       m2r;
    logic       rw;
    logic [1:0] pcs;
    logic       pcw;
    logic       ill;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011,
                                6'b000100, 6'b000010, 6'b001000};
  logic [5:0] legal_fns [5] = '{6'b100000, 6'b100010, 6'b100100,
                                6'b100101, 6'b101010};

  function automatic obs_t base(input logic [3:0] st);
    obs_t o;
    o     = '0;
    o.st  = st;
    o.alu = 3'b010;
    return o;
  endfunction

  function automatic obs_t quiet(input obs_t i);
    obs_t o;
    o     = i;
    o.mr  = 1'b0;
    o.mw  = 1'b0;
    o.irw = 1'b0;
    o.rw  = 1'b0;
    o.pcw = 1'b0;
    o.ill = 1'b0;
    return o;
  endfunction

  function automatic obs_t fetch_cycle();
    obs_t o;
    o     = base(4'd0);
    o.mr  = 1'b1;
    o.irw = 1'b1;
    o.b   = 2'b01;
    o.pcw = 1'b1;
    return o;
  endfunction

  // Arithmetic meaning of each supported funct, as an ALU code.
  function automatic logic [2:0] r_alu(input logic [5:0] fn, output logic ok);
    ok = 1'b1;
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default: begin
        ok = 1'b0;
        return 3'b010;
      end
    endcase
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.st   = bus.state;
    o.alu  = bus.aluCtl;
    o.a    = bus.aluSrcA;
    o.b    = bus.aluSrcB;
    o.iord = bus.iorD;
    o.mr   = bus.memRead;
    o.mw   = bus.memWrite;
    o.irw  = bus.irWrite;
    o.rd   = bus.regDst;
    o.m2r  = bus.memToReg;
    o.rw   = bus.regWrite;
    o.pcs  = bus.pcSrc;
    o.pcw  = bus.pcWrite;
    o.ill  = bus.illegal;
    return o;
  endfunction

  // Expected cycle-by-cycle schedule of one instruction.
  task automatic build_exp(input logic [5:0] op, input logic [5:0] fn, input logic z);
    obs_t o;
    logic ok;
    logic [2:0] f_alu;
    exp_q.delete();
    exp_q.push_back(fetch_cycle());
    o   = base(4'd1);
    o.b = 2'b11;
    if (op == 6'b100011 || op == 6'b101011) begin
      exp_q.push_back(o);
      o = base(4'd2); o.a = 1'b1; o.b = 2'b10;
      exp_q.push_back(o);
      if (op == 6'b100011) begin
        o = base(4'd3); o.iord = 1'b1; o.mr = 1'b1;
        exp_q.push_back(o);
        o = base(4'd4); o.m2r = 1'b1; o.rw = 1'b1;
        exp_q.push_back(o);
      end else begin
        o = base(4'd5); o.iord = 1'b1; o.mw = 1'b1;
        exp_q.push_back(o);
      end
    end else if (op == 6'b000000) begin
      exp_q.push_back(o);
      f_alu = r_alu(fn, ok);
      o = base(4'd6); o.a = 1'b1; o.b = 2'b00; o.alu = f_alu; o.ill = !ok;
      exp_q.push_back(o);
      if (ok) begin
        o = base(4'd7); o.rd = 1'b1; o.rw = 1'b1;
        exp_q.push_back(o);
      end
    end else if (op == 6'b000100) begin
      exp_q.push_back(o);
      o = base(4'd8); o.a = 1'b1; o.alu = 3'b110; o.pcs = 2'b01; o.pcw = z;
      exp_q.push_back(o);
    end else if (op == 6'b000010) begin
      exp_q.push_back(o);
      o = base(4'd9); o.pcs = 2'b10; o.pcw = 1'b1;
      exp_q.push_back(o);
    end else if (op == 6'b001000) begin
      exp_q.push_back(o);
      o = base(4'd10); o.a = 1'b1; o.b = 2'b10;
      exp_q.push_back(o);
      o = base(4'd11); o.rw = 1'b1;
      exp_q.push_back(o);
    end else begin
      o.ill = 1'b1;
      exp_q.push_back(o);
    end
  endtask

  task automatic check(input string tag, input int cyc, input obs_t exp);
    obs_t got;
    got = observe();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
    checks++;
    assert (!(got.mr && got.mw) && !(got.rw && got.pcw)) else begin
      failures++;
      $error("FAIL %s_excl cyc=%0d got=%h exp=no_conflict", tag, cyc, got);
    end
  endtask

  // Run one instruction from FETCH; optionally reset at cycle abort_at.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int abort_at, input int rst_cycles, input string tag);
    int n;
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    build_exp(op, fn, z);
    n = exp_q.size();
    if (abort_at >= 0 && abort_at < n) n = abort_at;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check(tag, k, exp_q[k]);
      @(posedge clk); #1;
    end
    if (abort_at >= 0 && abort_at < exp_q.size()) begin
      rst = 1'b1;
      @(negedge clk);
      check({tag, "_rst"}, abort_at, quiet(exp_q[abort_at]));
      for (int r = 1; r < rst_cycles; r++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_rst"}, abort_at + r, quiet(fetch_cycle()));
      end
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         ab;

    rst        = 1'b1;
    bus.opcode = '0;
    bus.funct  = '0;
    bus.zero   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset", 0, quiet(fetch_cycle()));
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed: lw aborted in MEMRD by a 2-cycle reset, then normal fetch.
    run_instr(6'b100011, 6'b000000, 1'b0, 3, 2, "lw_abort");
    run_instr(6'b000000, 6'b100010, 1'b0, -1, 0, "r_sub");
    run_instr(6'b000100, 6'b000000, 1'b1, -1, 0, "beq_taken");
    run_instr(6'b000100, 6'b000000, 1'b0, -1, 0, "beq_not");
    run_instr(6'b100011, 6'b000000, 1'b0, -1, 0, "lw");
    run_instr(6'b101011, 6'b000000, 1'b0, -1, 0, "sw");
    run_instr(6'b000010, 6'b000000, 1'b0, -1, 0, "j");
    run_instr(6'b001000, 6'b000000, 1'b0, -1, 0, "addi");
    run_instr(6'b111111, 6'b000000, 1'b0, -1, 0, "ill_op");
    run_instr(6'b000000, 6'b000000, 1'b0, -1, 0, "ill_fn");
    run_instr(6'b000000, 6'b101010, 1'b0, -1, 0, "r_slt");
    run_instr(6'b000000, 6'b100101, 1'b0, -1, 0, "r_or");

    // Random instruction stream with occasional mid-instruction resets.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 5)];
      else                           op = 6'($urandom);
      if ($urandom_range(0, 3) != 0) fn = legal_fns[$urandom_range(0, 4)];
      else                           fn = 6'($urandom);
      z  = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, fn, z, ab, int'($urandom_range(1, 2)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
